// File: rtl/riv_synchronizer_filter.sv
// riv_synchronizer_filter
// Per-channel multi-stage synchroniser for quasi-static asynchronous levels,
// with an optional stability (deglitch) filter and one-cycle rise/fall pulses.
// Every channel is independent; do not use this for coherent multi-bit buses.
module riv_synchronizer_filter #(
    parameter int               WIDTH         = 1,
    parameter int               STAGES        = 2,
    parameter logic [WIDTH-1:0] RST_VAL       = '0,
    parameter int               FILTER_CYCLES = 0
) (
    input  logic             dst_clk,
    input  logic             dst_rst_n,
    input  logic [WIDTH-1:0] src_in,
    output logic [WIDTH-1:0] dst_out,
    output logic [WIDTH-1:0] dst_rise,
    output logic [WIDTH-1:0] dst_fall
);

    // Reject parameter combinations that cannot produce a working chain.
    if (WIDTH < 1) begin : g_bad_width
        $error("riv_synchronizer_filter: WIDTH must be >= 1");
    end
    if (STAGES < 2) begin : g_bad_stages
        $error("riv_synchronizer_filter: STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 0) begin : g_bad_filter
        $error("riv_synchronizer_filter: FILTER_CYCLES must be >= 0");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        // sync_stage[0] samples the asynchronous input; sync_stage[STAGES-1]
        // is the first value safe to use in the dst_clk domain.
        (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_stage;
        logic s;
        logic lvl;
        logic prev;

        // Shift the raw input through the synchroniser chain.
        always_ff @(posedge dst_clk or negedge dst_rst_n) begin
            if (!dst_rst_n) begin
                sync_stage <= {STAGES{RST_VAL[i]}};
            end else begin
                sync_stage <= {sync_stage[STAGES-2:0], src_in[i]};
            end
        end

        assign s = sync_stage[STAGES-1];

        if (FILTER_CYCLES == 0) begin : g_bypass
            assign lvl = s;
        end else begin : g_filter
            localparam int             CNT_W    = $clog2(FILTER_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

            logic             f;
            logic [CNT_W-1:0] cnt;

            // Accept a new level only after FILTER_CYCLES consecutive cycles
            // of disagreement; any agreeing cycle restarts the count, so the
            // counter never exceeds FILTER_CYCLES-1 and cannot wrap.
            always_ff @(posedge dst_clk or negedge dst_rst_n) begin
                if (!dst_rst_n) begin
                    f   <= RST_VAL[i];
                    cnt <= '0;
                end else if (s == f) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    f   <= s;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            assign lvl = f;
        end

        // Remember last cycle's output level; resetting to RST_VAL keeps
        // reset release from looking like an edge.
        always_ff @(posedge dst_clk or negedge dst_rst_n) begin
            if (!dst_rst_n) begin
                prev <= RST_VAL[i];
            end else begin
                prev <= lvl;
            end
        end

        assign dst_out[i]  = lvl;
        assign dst_rise[i] = lvl & ~prev;
        assign dst_fall[i] = ~lvl & prev;
    end

endmodule

// File: tb/tb_riv_synchronizer_filter.sv
// Bench for riv_synchronizer_filter: two instances sharing one input bus,
// one unfiltered (STAGES=3, RST_VAL=F) and one filtered (STAGES=2,
// FILTER_CYCLES=4, RST_VAL=0110), checked against a window-based model of
// the input history plus directed literal expectations.
module tb_riv_synchronizer_filter;

    localparam int         W      = 4;
    localparam int         A_STG  = 3;
    localparam logic [3:0] A_RST  = 4'hF;
    localparam int         B_STG  = 2;
    localparam int         B_FC   = 4;
    localparam logic [3:0] B_RST  = 4'b0110;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] src = 4'hF;
    always #5 clk = ~clk;

    logic [W-1:0] a_out, a_rise, a_fall;
    logic [W-1:0] b_out, b_rise, b_fall;

    riv_synchronizer_filter #(
        .WIDTH(W), .STAGES(A_STG), .RST_VAL(A_RST), .FILTER_CYCLES(0)
    ) u_a (
        .dst_clk(clk), .dst_rst_n(rst_n), .src_in(src),
        .dst_out(a_out), .dst_rise(a_rise), .dst_fall(a_fall)
    );

    riv_synchronizer_filter #(
        .WIDTH(W), .STAGES(B_STG), .RST_VAL(B_RST), .FILTER_CYCLES(B_FC)
    ) u_b (
        .dst_clk(clk), .dst_rst_n(rst_n), .src_in(src),
        .dst_out(b_out), .dst_rise(b_rise), .dst_fall(b_fall)
    );

    // ---------------- scoreboard counters ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // hist[k] is src as seen at the k-th clock edge since reset release.
    // Before reset release every chain stage holds the instance's RST_VAL.
    logic [W-1:0] hist[$];
    logic [W-1:0] ma_out = A_RST, ma_prev = A_RST;
    logic [W-1:0] mb_out = B_RST, mb_prev = B_RST;

    function automatic logic [W-1:0] src_at(input int j, input logic [W-1:0] rv);
        if (j < 0) return rv;
        return hist[j];
    endfunction

    // A filtered bit flips at edge k when the synchronised value seen at the
    // last fc edges (edge j sees src from edge j-stages) was the opposite level.
    function automatic logic [W-1:0] filt_next(input int k, input int stages, input int fc,
                                               input logic [W-1:0] rv, input logic [W-1:0] f);
        logic [W-1:0] r;
        logic [W-1:0] v;
        logic ok;
        r = f;
        for (int b = 0; b < W; b++) begin
            ok = 1'b1;
            for (int j = k - fc + 1; j <= k; j++) begin
                v = src_at(j - stages, rv);
                if (v[b] == f[b]) ok = 1'b0;
            end
            if (ok) r[b] = ~f[b];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int k;
        if (!rst_n) begin
            hist.delete();
            ma_out = A_RST; ma_prev = A_RST;
            mb_out = B_RST; mb_prev = B_RST;
        end else begin
            hist.push_back(src);
            k = hist.size() - 1;
            ma_prev = ma_out;
            ma_out  = src_at(k - A_STG + 1, A_RST);
            mb_prev = mb_out;
            mb_out  = filt_next(k, B_STG, B_FC, B_RST, mb_out);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_out",  a_out,  ma_out);
            chk("a_rise", a_rise, ma_out & ~ma_prev);
            chk("a_fall", a_fall, ~ma_out & ma_prev);
            chk("b_out",  b_out,  mb_out);
            chk("b_rise", b_rise, mb_out & ~mb_prev);
            chk("b_fall", b_fall, ~mb_out & mb_prev);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset with all inputs high: A sits at its all-ones reset value.
        rst_n = 1'b0;
        src   = 4'hF;
        wait_neg(3);
        chk_en = 1'b1;
        chk("rst_a_out", a_out, 4'hF);
        chk("rst_b_out", b_out, 4'b0110);
        chk("rst_a_pulse", a_rise | a_fall, 4'h0);
        chk("rst_b_pulse", b_rise | b_fall, 4'h0);

        // Release: A never pulses; B adopts 1111 after 2+4 edges.
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("p1_a_out", a_out, 4'hF);
            chk("p1_a_pulse", a_rise | a_fall, 4'h0);
            chk("p1_b_out", b_out, (k < 6) ? 4'b0110 : 4'b1111);
            chk("p1_b_rise", b_rise, (k == 6) ? 4'b1001 : 4'b0000);
        end

        // Multi-bit change: A follows after 3 edges, B after 6.
        src = 4'b0101;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("p2_a_out", a_out, (k < 3) ? 4'hF : 4'b0101);
            chk("p2_a_fall", a_fall, (k == 3) ? 4'b1010 : 4'b0000);
            chk("p2_b_out", b_out, (k < 6) ? 4'hF : 4'b0101);
            chk("p2_b_fall", b_fall, (k == 6) ? 4'b1010 : 4'b0000);
            chk("p2_b_rise", b_rise, 4'b0000);
        end

        // Glitches on bit 0 shorter than the filter never reach B.
        src = 4'b0100;
        wait_neg(10);
        src = 4'b0101; wait_neg(3);
        src = 4'b0100;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("p3_glitch_out", b_out, 4'b0100);
            chk("p3_glitch_rise", b_rise, 4'b0000);
        end
        src = 4'b0101; wait_neg(3);
        src = 4'b0100; wait_neg(1);
        src = 4'b0101; wait_neg(3);
        src = 4'b0100;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("p3_split_out", b_out, 4'b0100);
            chk("p3_split_rise", b_rise, 4'b0000);
        end
        // A held level is accepted after exactly 2+4 edges.
        src = 4'b0101;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("p3_accept_out", b_out, (k < 6) ? 4'b0100 : 4'b0101);
            chk("p3_accept_rise", b_rise, (k == 6) ? 4'b0001 : 4'b0000);
        end

        // Reset in the middle of a count discards it.
        src = 4'b0100;
        wait_neg(4);
        #2 rst_n = 1'b0;
        #1;
        chk("p4_rst_a_out", a_out, 4'hF);
        chk("p4_rst_b_out", b_out, 4'b0110);
        chk("p4_rst_pulse", a_rise | a_fall | b_rise | b_fall, 4'h0);
        wait_neg(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("p4_b_out", b_out, (k < 6) ? 4'b0110 : 4'b0100);
            chk("p4_b_fall", b_fall, (k == 6) ? 4'b0010 : 4'b0000);
            chk("p4_b_rise", b_rise, 4'b0000);
            chk("p4_a_out", a_out, (k < 3) ? 4'hF : 4'b0100);
            chk("p4_a_fall", a_fall, (k == 3) ? 4'b1011 : 4'b0000);
        end

        // Toggling every cycle never gets through the filter.
        for (int i = 0; i < 20; i++) begin
            src = (i % 2 == 0) ? 4'hF : 4'h0;
            @(negedge clk);
            chk("p5_toggle_out", b_out, 4'b0100);
        end
        src = 4'b0100;
        wait_neg(10);

        // Randomised levels, hold times, toggle bursts and resets.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                #3 rst_n = 1'b0;
                wait_neg($urandom_range(1, 3));
                rst_n = 1'b1;
            end else if ($urandom_range(0, 9) == 0) begin
                for (int t = 0; t < $urandom_range(2, 10); t++) begin
                    src = ~src;
                    @(negedge clk);
                end
            end else begin
                src = W'($urandom_range(0, 15));
                wait_neg($urandom_range(1, 8));
            end
        end
        wait_neg(10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
